// File: rtl/audio_decimator.sv
// audio_decimator
// Boxcar decimator for the mixed TIA audio word: averages 2**LOG2_DECIM
// input samples into one output sample, optionally removes DC with a
// first-order leaky high-pass, and hands the result to the audio sink over
// a valid/ready handshake with a sticky overrun flag.
//
// Pipeline timing, with E the edge that takes the last ce_in of a block:
//   E    : block sum shifted down into avg, avg_stb pulses
//   E+1  : DC stage (or bypass) loads out_data, out_valid rises

module audio_decimator #(
    parameter int LOG2_DECIM = 7,
    parameter bit DCB_EN     = 1'b1,
    parameter int DCB_SHIFT  = 8
) (
    input  logic        sysclk_7_143,
    input  logic        reset,
    input  logic        ce_in,
    input  logic [15:0] audio_in,
    input  logic        mute,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overrun
);

    localparam int ACC_W = 16 + LOG2_DECIM;

    // Accumulator stage
    logic signed [ACC_W-1:0]      acc;
    logic signed [ACC_W-1:0]      acc_sum;
    logic signed [ACC_W-1:0]      acc_shift;
    logic [LOG2_DECIM-1:0]        cnt;
    logic signed [15:0]           x_in;
    logic                         boundary;

    // Averaged sample and its one-cycle strobe
    logic signed [15:0]           avg;
    logic                         avg_stb;

    // DC-blocking stage
    logic signed [15:0]           x_prev;
    logic signed [15:0]           y_prev;
    logic signed [15:0]           y_leak;
    logic signed [17:0]           avg_ext;
    logic signed [17:0]           x_prev_ext;
    logic signed [17:0]           y_prev_ext;
    logic signed [17:0]           y_leak_ext;
    logic signed [17:0]           y_raw;
    logic signed [15:0]           y_sat;
    logic [15:0]                  stage_out;

    // Input selection, running sum and block-boundary detection
    always_comb begin
        x_in      = mute ? 16'sd0 : $signed(audio_in);
        acc_sum   = acc + {{LOG2_DECIM{x_in[15]}}, x_in};
        acc_shift = acc_sum >>> LOG2_DECIM;
        boundary  = ce_in && (cnt == {LOG2_DECIM{1'b1}});
    end

    // Accumulate one sample per ce_in; at the boundary publish the average and restart
    always_ff @(posedge sysclk_7_143) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            avg     <= '0;
            avg_stb <= 1'b0;
        end else begin
            avg_stb <= 1'b0;
            if (ce_in) begin
                if (boundary) begin
                    // Sum of 2**LOG2_DECIM 16-bit words fits ACC_W bits, so the
                    // shifted result always fits back in 16 bits.
                    avg     <= acc_shift[15:0];
                    avg_stb <= 1'b1;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + LOG2_DECIM'(1);
                end
            end
        end
    end

    // High-pass difference equation in 18 bits, saturated back to 16
    always_comb begin
        y_leak     = y_prev >>> DCB_SHIFT;
        avg_ext    = {{2{avg[15]}}, avg};
        x_prev_ext = {{2{x_prev[15]}}, x_prev};
        y_prev_ext = {{2{y_prev[15]}}, y_prev};
        y_leak_ext = {{2{y_leak[15]}}, y_leak};
        // Worst case magnitude is 3*32768, inside the 18-bit signed range.
        y_raw      = avg_ext - x_prev_ext + y_prev_ext - y_leak_ext;
        if (y_raw > 18'sd32767) begin
            y_sat = 16'sh7FFF;
        end else if (y_raw < -18'sd32768) begin
            y_sat = 16'sh8000;
        end else begin
            y_sat = y_raw[15:0];
        end
        stage_out = DCB_EN ? y_sat : avg;
    end

    // Filter history advances once per averaged sample
    always_ff @(posedge sysclk_7_143) begin
        if (reset) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (avg_stb) begin
            x_prev <= avg;
            y_prev <= y_sat;
        end
    end

    // Output holding register: newest sample always wins, a lost one sets overrun
    always_ff @(posedge sysclk_7_143) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (avg_stb) begin
                out_data  <= stage_out;
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_decimator.sv
// tb_audio_decimator
// Runs a bypass instance (DCB_EN=0) and a DC-blocking instance (DCB_EN=1)
// side by side on the same stimulus. Each block of samples pushes the
// expected output of each instance into its own queue; a monitor pops and
// compares whenever a transfer is about to happen.

module tb_audio_decimator;

    logic        sysclk;
    logic        reset;
    logic        ce_in;
    logic [15:0] audio_in;
    logic        mute;
    logic        out_ready;

    logic [15:0] out_data0, out_data1;
    logic        out_valid0, out_valid1;
    logic        overrun0, overrun1;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int blk_sum;
    int xp, yp;

    audio_decimator #(.LOG2_DECIM(7), .DCB_EN(1'b0), .DCB_SHIFT(8)) dut0 (
        .sysclk_7_143 (sysclk),
        .reset        (reset),
        .ce_in        (ce_in),
        .audio_in     (audio_in),
        .mute         (mute),
        .out_data     (out_data0),
        .out_valid    (out_valid0),
        .out_ready    (out_ready),
        .overrun      (overrun0)
    );

    audio_decimator #(.LOG2_DECIM(7), .DCB_EN(1'b1), .DCB_SHIFT(8)) dut1 (
        .sysclk_7_143 (sysclk),
        .reset        (reset),
        .ce_in        (ce_in),
        .audio_in     (audio_in),
        .mute         (mute),
        .out_data     (out_data1),
        .out_valid    (out_valid1),
        .out_ready    (out_ready),
        .overrun      (overrun1)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // A transfer happens on the next rising edge; compare against the scoreboard
    always @(negedge sysclk) begin
        if (!reset && out_ready) begin
            if (out_valid0) begin
                if (q0.size() == 0) check_val("unexpected_out0", {16'h0, out_data0}, 32'hDEAD_0000);
                else check_val("data_bypass", {16'h0, out_data0}, {16'h0, q0.pop_front()});
            end
            if (out_valid1) begin
                if (q1.size() == 0) check_val("unexpected_out1", {16'h0, out_data1}, 32'hDEAD_0001);
                else check_val("data_dcb", {16'h0, out_data1}, {16'h0, q1.pop_front()});
            end
        end
    end

    // Drive n ce_in cycles, alternating a/b when alt is set; sums the effective input
    task automatic drive_samples(input int n, input logic [15:0] a, input logic [15:0] b,
                                 input bit alt, input bit m);
        logic signed [15:0] sv;
        blk_sum = 0;
        for (int i = 0; i < n; i++) begin
            ce_in    = 1'b1;
            audio_in = (alt && (i % 2 == 1)) ? b : a;
            mute     = m;
            sv       = audio_in;
            if (!m) blk_sum += sv;
            @(posedge sysclk); #1;
        end
        ce_in = 1'b0;
        mute  = 1'b0;
    endtask

    // Full block plus expected results for both instances
    task automatic drive_block(input logic [15:0] a, input logic [15:0] b, input bit alt, input bit m);
        int avg, y;
        drive_samples(128, a, b, alt, m);
        avg = blk_sum >>> 7;
        y   = avg - xp + yp - (yp >>> 8);
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        xp = avg;
        yp = y;
        q0.push_back(avg[15:0]);
        q1.push_back(y[15:0]);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 50) begin
            @(posedge sysclk); #1;
            t++;
        end
        check_val(tag, t < 50 ? 32'd0 : 32'd1, 32'd0);
        @(posedge sysclk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge sysclk); #1;
        @(posedge sysclk); #1;
        reset = 1'b0;
        q0.delete();
        q1.delete();
        xp = 0;
        yp = 0;
    endtask

    initial begin
        reset     = 1'b1;
        ce_in     = 1'b0;
        audio_in  = '0;
        mute      = 1'b0;
        out_ready = 1'b0;
        xp        = 0;
        yp        = 0;
        @(posedge sysclk); #1;
        @(posedge sysclk); #1;
        check_val("rst_data0",  {16'h0, out_data0}, 32'h0);
        check_val("rst_valid0", {31'h0, out_valid0}, 32'h0);
        check_val("rst_ovr0",   {31'h0, overrun0},  32'h0);
        check_val("rst_data1",  {16'h0, out_data1}, 32'h0);
        check_val("rst_valid1", {31'h0, out_valid1}, 32'h0);
        reset = 1'b0;

        // Constant block and two-edge latency
        drive_block(16'h0100, 16'h0100, 1'b0, 1'b0);
        check_val("latency_e", {31'h0, out_valid0}, 32'h0);
        @(posedge sysclk); #1;
        check_val("latency_e1", {31'h0, out_valid0}, 32'h1);
        check_val("lat_data", {16'h0, out_data0}, 32'h0100);
        out_ready = 1'b1;
        wait_drain("drain_t1");
        check_val("t1_single", {31'h0, out_valid0}, 32'h0);

        // Alternating +/- cancels, then -1 stays -1 after floor shift
        drive_block(16'h0400, 16'hFC00, 1'b1, 1'b0);
        wait_drain("drain_t2a");
        drive_block(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_drain("drain_t2b");

        // DC blocker decay from a step: 1000, 0FF0, 0FE1
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_block(16'h1000, 16'h1000, 1'b0, 1'b0);
            wait_drain("drain_t3");
        end

        // Full-scale negative then positive block saturates the filter
        do_reset();
        out_ready = 1'b1;
        drive_block(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_drain("drain_t4a");
        drive_block(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        wait_drain("drain_t4b");

        // Sink stalls across two boundaries
        out_ready = 1'b0;
        drive_block(16'h1111, 16'h1111, 1'b0, 1'b0);
        @(posedge sysclk); #1;
        check_val("ovr_before", {31'h0, overrun0}, 32'h0);
        drive_block(16'h2222, 16'h2222, 1'b0, 1'b0);
        @(posedge sysclk); #1;
        void'(q0.pop_front());
        void'(q1.pop_front());
        check_val("ovr_set0", {31'h0, overrun0}, 32'h1);
        check_val("ovr_set1", {31'h0, overrun1}, 32'h1);
        check_val("ovr_newest", {16'h0, out_data0}, 32'h2222);
        out_ready = 1'b1;
        wait_drain("drain_t5");
        check_val("t5_valid_low", {31'h0, out_valid0}, 32'h0);
        repeat (5) @(posedge sysclk);
        #1;
        check_val("ovr_sticky", {31'h0, overrun0}, 32'h1);

        // Reset with a sample pending and a partial sum accumulated
        out_ready = 1'b0;
        drive_block(16'h0300, 16'h0300, 1'b0, 1'b0);
        drive_samples(60, 16'h0700, 16'h0700, 1'b0, 1'b0);
        check_val("t6_pending", {31'h0, out_valid0}, 32'h1);
        reset = 1'b1;
        @(posedge sysclk); #1;
        check_val("t6_data0",  {16'h0, out_data0}, 32'h0);
        check_val("t6_valid0", {31'h0, out_valid0}, 32'h0);
        check_val("t6_ovr0",   {31'h0, overrun0},  32'h0);
        check_val("t6_valid1", {31'h0, out_valid1}, 32'h0);
        check_val("t6_ovr1",   {31'h0, overrun1},  32'h0);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        xp = 0;
        yp = 0;
        out_ready = 1'b1;
        drive_block(16'h0200, 16'h0200, 1'b0, 1'b0);
        wait_drain("drain_t6a");
        drive_block(16'h5555, 16'h5555, 1'b0, 1'b1);
        wait_drain("drain_t6b");
        repeat (10) @(posedge sysclk);
        #1;
        check_val("t6_idle", {31'h0, out_valid0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
